// File: rtl/cache_pkg.sv
// Shared types and geometry for the 4-line direct-mapped cache controller.
package cache_pkg;

  localparam int LINES  = 4;
  localparam int IDX_W  = 2;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    RD_WAIT = 3'd2,
    MEM_RD  = 3'd3,
    MEM_WR  = 3'd4,
    FILL    = 3'd5,
    DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, main-memory and data-array pins of the cache controller bundled as one bus.
interface cache_ctrl_if #(
  parameter int ADDR_W = 8
);
  import cache_pkg::*;

  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_W-1:0]    cpu_addr;
  logic [DATA_W-1:0]    cpu_wdata;
  logic [DATA_W-1:0]    cpu_rdata;
  logic                 cpu_done;

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 mem_ack;

  logic                 arr_wr_en;
  logic                 arr_rd_en;
  logic [IDX_W-1:0]     arr_addr;
  logic [DATA_W-1:0]    arr_data;
  logic [DATA_W-1:0]    arr_q;

  // Controller side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack, arr_q,
    output cpu_rdata, cpu_done, mem_req, mem_we, mem_addr, mem_wdata,
    output arr_wr_en, arr_rd_en, arr_addr, arr_data
  );

  // CPU / memory / array side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack, arr_q,
    input  cpu_rdata, cpu_done, mem_req, mem_we, mem_addr, mem_wdata,
    input  arr_wr_en, arr_rd_en, arr_addr, arr_data
  );

endinterface

// File: rtl/cache_tag_store.sv
// Tag + valid bits for the four direct-mapped lines: one async read port,
// one write port and a single-cycle clear of every valid bit.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];

  // Next-state of the tag/valid table; flush and write never coincide.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (flush) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
    end else begin
      valid_d = valid_q;
    end
  end

  // Tag/valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Request controller for the 4-entry write-through, write-allocate cache:
// hit/miss decision, memory fetch/write-through handshake and statistics.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  cache_ctrl_if.slave      bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int TAG_W = ADDR_W - IDX_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]    idx_s;
  logic [TAG_W-1:0]    tag_s;
  logic                rd_valid_s;
  logic [TAG_W-1:0]    rd_tag_s;
  logic                hit_s;
  logic                flush_s;
  logic                tag_wr_s;

  logic                mem_req_s, mem_we_s, arr_wr_en_s, arr_rd_en_s, cpu_done_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s, arr_data_s;
  logic [IDX_W-1:0]    arr_addr_s;

  assign idx_s    = addr_q[IDX_W-1:0];
  assign tag_s    = addr_q[ADDR_W-1:IDX_W];
  assign hit_s    = rd_valid_s && (rd_tag_s == tag_s);
  assign flush_s  = (state_q == IDLE) && flush;
  assign tag_wr_s = (state_q == FILL);

  cache_tag_store #(.TAG_W(TAG_W)) u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush_s),
    .rd_idx   (idx_s),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .wr_en    (tag_wr_s),
    .wr_idx   (idx_s),
    .wr_tag   (tag_s)
  );

  // Next-state, request latches, read-data and statistics update.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    fill_d     = fill_q;
    rdata_d    = rdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        // flush wins; a same-cycle request stays pending for the next cycle
        if (flush) begin
          state_d = IDLE;
        end else if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          we_d    = bus.cpu_we;
          wdata_d = bus.cpu_wdata;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s) begin
          hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
        if (we_q) begin
          state_d = MEM_WR;
        end else if (hit_s) begin
          state_d = RD_WAIT;
        end else begin
          state_d = MEM_RD;
        end
      end
      RD_WAIT: begin
        rdata_d = bus.arr_q;
        state_d = DONE;
      end
      MEM_RD: begin
        if (bus.mem_ack) begin
          fill_d  = bus.mem_rdata;
          state_d = FILL;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_WR: begin
        if (bus.mem_ack) begin
          state_d = FILL;
        end else begin
          state_d = MEM_WR;
        end
      end
      FILL: begin
        if (!we_q) begin
          rdata_d = fill_q;
        end else begin
          rdata_d = rdata_q;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and registered data only.
  always_comb begin
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    arr_wr_en_s = 1'b0;
    arr_rd_en_s = 1'b0;
    arr_addr_s  = '0;
    arr_data_s  = '0;
    cpu_done_s  = 1'b0;
    case (state_q)
      LOOKUP: begin
        if (hit_s && !we_q) begin
          arr_rd_en_s = 1'b1;
          arr_addr_s  = idx_s;
        end else begin
          arr_rd_en_s = 1'b0;
        end
      end
      MEM_RD: begin
        mem_req_s  = 1'b1;
        mem_addr_s = addr_q;
      end
      MEM_WR: begin
        mem_req_s   = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = addr_q;
        mem_wdata_s = wdata_q;
      end
      FILL: begin
        arr_wr_en_s = 1'b1;
        arr_addr_s  = idx_s;
        arr_data_s  = we_q ? wdata_q : fill_q;
      end
      DONE:    cpu_done_s = 1'b1;
      default: cpu_done_s = 1'b0;
    endcase
  end

  // Controller state, request latches and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      fill_q     <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      fill_q     <= fill_d;
      rdata_q    <= rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_done  = cpu_done_s;
  assign bus.mem_req   = mem_req_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.arr_wr_en = arr_wr_en_s;
  assign bus.arr_rd_en = arr_rd_en_s;
  assign bus.arr_addr  = arr_addr_s;
  assign bus.arr_data  = arr_data_s;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: transaction table with a scoreboard queue, a 1-cycle
// data-array model, plus flush and mid-transaction reset sequences.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] hit_cnt, miss_cnt;

  cache_ctrl_if #(.ADDR_W(8)) bus ();

  cache_ctrl #(.ADDR_W(8), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  // Data array model with registered read output.
  logic [7:0] arr_mem [4];
  always @(posedge clk) begin
    if (bus.arr_wr_en) arr_mem[bus.arr_addr] <= bus.arr_data;
    if (bus.arr_rd_en) bus.arr_q <= arr_mem[bus.arr_addr];
  end

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] mdata;
    int         dly;
    logic       hit;
    logic [7:0] rdata;
  } vec_t;

  typedef struct {
    logic       hit;
    logic [7:0] rdata;
    int         done_at;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[8];
  int   n_pass = 0;
  int   n_total = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic do_txn(input vec_t v, input logic with_flush);
    exp_t       e;
    exp_t       got;
    int         cyc, wait_n, done_at;
    bit         done, saw_req, saw_wr, saw_rd, mem_stable, popped, exp_mem;
    logic [7:0] ma, mwd, wr_data, rd;
    logic       mwe;
    logic [1:0] wr_idx, rd_idx;
    e.hit     = v.hit;
    e.rdata   = v.rdata;
    e.done_at = (v.hit && !v.we) ? 3 : 4 + v.dly;
    if (with_flush) e.done_at = e.done_at + 1;
    sbq.push_back(e);
    done = 0; saw_req = 0; saw_wr = 0; saw_rd = 0; mem_stable = 1; popped = 0;
    cyc = 0; wait_n = 0; done_at = -1; rd = 8'h00;
    ma = 8'h00; mwd = 8'h00; mwe = 1'b0; wr_data = 8'h00; wr_idx = 2'd0; rd_idx = 2'd0;
    got = e;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = v.we;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    flush         = with_flush;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      flush       = 1'b0;
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (!saw_req) begin
          ma = bus.mem_addr; mwe = bus.mem_we; mwd = bus.mem_wdata; saw_req = 1;
        end else if (bus.mem_addr !== ma || bus.mem_we !== mwe || bus.mem_wdata !== mwd) begin
          mem_stable = 0;
        end
        if (wait_n == v.dly) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = v.mdata;
        end
        wait_n++;
      end
      if (bus.arr_wr_en) begin saw_wr = 1; wr_idx = bus.arr_addr; wr_data = bus.arr_data; end
      if (bus.arr_rd_en) begin saw_rd = 1; rd_idx = bus.arr_addr; end
      if (bus.cpu_done) begin
        done = 1; done_at = cyc; rd = bus.cpu_rdata; bus.cpu_req = 1'b0;
        got = sbq.pop_front(); popped = 1;
      end
    end
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
    if (!popped) got = sbq.pop_front();
    chk("cpu_done_seen", done, 1'b1);
    @(negedge clk);
    chk("cpu_done_pulse", bus.cpu_done, 1'b0);
    chk("cpu_rdata", rd, got.rdata);
    chk("done_latency", done_at, got.done_at);
    if (got.hit) exp_hits++;
    else exp_miss++;
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_miss);
    exp_mem = !v.hit || v.we;
    chk("mem_req_seen", saw_req, exp_mem);
    if (exp_mem) begin
      chk("mem_addr", ma, v.addr);
      chk("mem_we", mwe, v.we);
      if (v.we) chk("mem_wdata", mwd, v.wdata);
      chk("mem_stable", mem_stable, 1'b1);
      chk("arr_wr_seen", saw_wr, 1'b1);
      chk("arr_wr_idx", wr_idx, v.addr[1:0]);
      chk("arr_wr_data", wr_data, v.we ? v.wdata : v.mdata);
      chk("arr_rd_absent", saw_rd, 1'b0);
    end else begin
      chk("arr_rd_seen", saw_rd, 1'b1);
      chk("arr_rd_idx", rd_idx, v.addr[1:0]);
      chk("arr_wr_absent", saw_wr, 1'b0);
    end
  endtask

  initial begin
    vec_t fv;
    bit   act;
    vecs[0] = '{1'b0, 8'h05, 8'h00, 8'hA5, 0, 1'b0, 8'hA5};
    vecs[1] = '{1'b0, 8'h05, 8'h00, 8'h00, 0, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 8'h01, 8'h00, 8'h11, 2, 1'b0, 8'h11};
    vecs[3] = '{1'b0, 8'h05, 8'h00, 8'hA5, 1, 1'b0, 8'hA5};
    vecs[4] = '{1'b1, 8'h0A, 8'h3C, 8'h00, 0, 1'b0, 8'hA5};
    vecs[5] = '{1'b0, 8'h0A, 8'h00, 8'h00, 0, 1'b1, 8'h3C};
    vecs[6] = '{1'b1, 8'h05, 8'h77, 8'h00, 3, 1'b1, 8'h3C};
    vecs[7] = '{1'b0, 8'h05, 8'h00, 8'h00, 0, 1'b1, 8'h77};

    rst_n = 1'b0; flush = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_cpu_done", bus.cpu_done, 1'b0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_arr_en", {bus.arr_wr_en, bus.arr_rd_en}, 2'b00);
    chk("rst_counters", {hit_cnt, miss_cnt}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) do_txn(vecs[i], 1'b0);

    // flush together with a request: request is taken one cycle later and misses
    fv = '{1'b0, 8'h0A, 8'h00, 8'h5A, 1, 1'b0, 8'h5A};
    do_txn(fv, 1'b1);

    // reset while waiting in MEM_RD
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h09;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_req) break;
    end
    chk("mem_req_before_rst", bus.mem_req, 1'b1);
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    chk("rst_drops_mem_req", bus.mem_req, 1'b0);
    chk("rst_clears_counters", {hit_cnt, miss_cnt}, 32'h0);
    chk("rst_clears_rdata", bus.cpu_rdata, 8'h00);
    exp_hits = 0;
    exp_miss = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE;
    act = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      act = act | bus.mem_req | bus.cpu_done | bus.arr_wr_en | bus.arr_rd_en;
    end
    chk("stray_ack_idle", act, 1'b0);
    fv = '{1'b0, 8'h05, 8'h00, 8'hA5, 2, 1'b0, 8'hA5};
    do_txn(fv, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Request controller sitting directly upstream of the 4-entry, 8-bit cache data array. It accepts CPU read/write requests, keeps the tag/valid store for the four direct-mapped lines, and decides hit or miss. It drives the array's write-enable, read-enable, address and data pins, and handles main-memory fetches (read miss) and write-through (all writes) over a req/ack handshake. It also keeps hit/miss statistics.

## Interface
Parameters:
- ADDR_W, 8, CPU/memory byte-address width; index = addr[1:0], tag = addr[ADDR_W-1:2]
- CNT_W, 16, width of hit/miss counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  invalidate all lines (acted on in IDLE only)
- cpu_req  in  1  request, held until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data, valid while cpu_done = 1, held until next read completes
- cpu_done  out  1  one-cycle completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle memory acknowledge
- arr_wr_en, arr_rd_en  out  1  data-array enables
- arr_addr  out  2  data-array index
- arr_data  out  8  data-array write data
- arr_q  in  8  data-array registered read output (1-cycle latency)
- hit_cnt, miss_cnt  out  CNT_W  lookup statistics, wrap on overflow

## Operation
- FSM states: IDLE, LOOKUP, RD_WAIT, MEM_RD, MEM_WR, FILL, DONE.
- IDLE: if flush = 1, clear all valid bits in that cycle. flush has priority over a same-cycle cpu_req, which stays pending and is sampled next cycle. Otherwise, with cpu_req = 1, latch addr/we/wdata and go to LOOKUP.
- LOOKUP: a line hits when valid[idx] is set and tag[idx] equals the latched tag. Increment hit_cnt or miss_cnt; reads and writes both count.
  - Read hit: arr_rd_en = 1, arr_addr = idx, go to RD_WAIT.
  - Read miss: go to MEM_RD.
  - Write (hit or miss): go to MEM_WR.
- RD_WAIT: load cpu_rdata from arr_q, go to DONE.
- MEM_RD: mem_req = 1, mem_we = 0, mem_addr = latched addr. On mem_ack, capture mem_rdata and go to FILL.
- MEM_WR: mem_req = 1, mem_we = 1, mem_wdata = latched wdata. On mem_ack, go to FILL.
- FILL: arr_wr_en = 1, arr_addr = idx, arr_data = fill data (read) or wdata (write). Write tag[idx] and set valid[idx]. On a read, load cpu_rdata with the fill data. Go to DONE.
- Policy is write-through, write-allocate. Aliasing addresses (same idx, different tag) evict the resident line.
- DONE: cpu_done = 1 for one cycle, then IDLE. cpu_req is ignored in DONE. If cpu_req is still high in the following IDLE cycle, it is a new request.
- mem_ack outside MEM_RD/MEM_WR is ignored. cpu_req outside IDLE is ignored.
- Writes leave cpu_rdata unchanged.

## Timing
- Reset (rst_n = 0, asynchronous):
  - state = IDLE, all valid bits cleared, tags = 0.
  - All outputs = 0: cpu_rdata, cpu_done, mem_*, arr_*, hit_cnt, miss_cnt.
  - A reset mid-transaction drops mem_req immediately and abandons the transaction. An ack arriving after reset release is ignored.
- Request sampled at edge E0; LOOKUP occupies E0–E1.
- Read hit: arr_rd_en high in E0–E1, cpu_done high in E2–E3. No memory traffic.
- Miss or write: mem_req rises in E1–E2. If mem_ack is high in the cycle ending at edge Ea, FILL occupies Ea to Ea+1 and cpu_done is high from Ea+1 to Ea+2.
- mem_req, mem_we, mem_addr and mem_wdata stay stable while waiting for mem_ack. mem_ack may arrive in the first mem_req cycle.
- Outputs are decoded from state and registered data only; there is no combinational path from cpu_* or mem_ack to outputs.
- Counter width rule: counters wrap from 2^CNT_W-1 to 0.

## Structure
- Shared package cache_pkg holds: the state enum, LINES = 4, IDX_W = 2, DATA_W = 8.
- One sub-module, cache_tag_store: four tag+valid entries with one read port, one write port and a single-cycle flush clear, both async-reset.
- The FSM, latches and counters stay in cache_ctrl.

## Test plan
- Reset, read 0x05 → mem_req with mem_addr 0x05; ack with 0xA5 → arr_wr_en with arr_addr 1 and arr_data 0xA5; cpu_rdata 0xA5; miss_cnt 1.
- Read 0x05 again → no mem_req, arr_rd_en with arr_addr 1, cpu_done two cycles after sampling, cpu_rdata 0xA5, hit_cnt 1.
- Read 0x01 (same index, new tag; ack 0x11) → miss with cpu_rdata 0x11; a following read of 0x05 misses again (miss_cnt 3).
- Write 0x0A with 0x3C → mem_we = 1, mem_wdata 0x3C, array index 2 written; a following read of 0x0A hits and returns 0x3C.
- flush and cpu_req in the same IDLE cycle → all lines invalid, request taken next cycle; read 0x0A then misses.
- rst_n low while in MEM_RD → mem_req drops immediately, counters are 0; a stray mem_ack after release causes no activity; read 0x05 misses.
